// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the core's instruction and data word ports onto one
// 64-bit burst memory port. Every transaction reads the whole line; stores
// merge their bytes into the line buffer and write the line back.
module mem_arbiter #(
  parameter int unsigned BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        instr_read,
  input  logic [31:0] instr_mem_address,
  output logic        instr_mem_resp,
  output logic [31:0] instr_mem_rdata,

  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_mbe,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_wdata,
  output logic        data_mem_resp,
  output logic [31:0] data_mem_rdata,

  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [63:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [63:0] pmem_rdata
);

  localparam int unsigned BW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFS = BW + 3;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    RESP
  } state_t;

  state_t state, state_d;

  logic [BW-1:0]             beat;
  logic [BEATS-1:0][63:0]    line;
  logic [BEATS-1:0][63:0]    line_d;

  // Latched transaction; address bits [1:0] are never needed.
  logic                      txn_data;
  logic                      txn_write;
  logic [31:2]               txn_addr;
  logic [3:0]                txn_mbe;
  logic [31:0]               txn_wdata;

  // fair: instr wins the next arbitration once.
  // waited: instr_read has been high for every cycle of the current data grant.
  logic                      fair;
  logic                      waited;

  logic [31:0]               instr_rdata_q;
  logic [31:0]               data_rdata_q;

  logic                      data_req;
  logic                      grant_instr;
  logic                      grant_data;
  logic                      last_beat;
  logic [BW-1:0]             tgt_beat;
  logic [31:0]               resp_word;
  logic [63:0]               merge_mask;
  logic [63:0]               merge_data;
  logic [7:0]                lane_en;

  logic                      unused_addr_lsb;
  assign unused_addr_lsb = ^{instr_mem_address[1:0], data_mem_address[1:0]};

  assign data_req    = data_read | data_write;
  assign grant_instr = instr_read & (fair | ~data_req);
  assign grant_data  = data_req & ~(fair & instr_read);
  assign last_beat   = pmem_resp && (beat == BW'(BEATS - 1));
  assign tgt_beat    = txn_addr[OFS-1:3];
  assign resp_word   = txn_addr[2] ? line[tgt_beat][63:32] : line[tgt_beat][31:0];

  // Byte-lane write mask and positioned store data for the line merge
  always_comb begin
    lane_en    = txn_addr[2] ? {txn_mbe, 4'b0000} : {4'b0000, txn_mbe};
    merge_data = txn_addr[2] ? {txn_wdata, 32'h0} : {32'h0, txn_wdata};
    merge_mask = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      merge_mask[i*8 +: 8] = {8{lane_en[i]}};
    end
  end

  // Next line buffer: capture read beats; on the final read beat of a store,
  // merge in the same cycle so the first write beat already carries it.
  always_comb begin
    line_d = line;
    if (state == RD_BURST && pmem_resp) begin
      line_d[beat] = pmem_rdata;
      if (last_beat && txn_write) begin
        line_d[tgt_beat] = (line_d[tgt_beat] & ~merge_mask) | (merge_data & merge_mask);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (grant_instr || grant_data) begin
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (last_beat) begin
          state_d = (txn_write && txn_mbe != '0) ? WR_BURST : RESP;
        end
      end
      WR_BURST: begin
        if (last_beat) begin
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latch, beat counter, line buffer, fairness and held rdata
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat          <= '0;
      line          <= '0;
      txn_data      <= 1'b0;
      txn_write     <= 1'b0;
      txn_addr      <= '0;
      txn_mbe       <= '0;
      txn_wdata     <= '0;
      fair          <= 1'b0;
      waited        <= 1'b0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      line <= line_d;
      unique case (state)
        IDLE: begin
          if (grant_instr || grant_data) begin
            txn_data  <= grant_data;
            txn_write <= grant_data & data_write;
            txn_addr  <= grant_data ? data_mem_address[31:2] : instr_mem_address[31:2];
            txn_mbe   <= grant_data ? data_mbe : '0;
            txn_wdata <= grant_data ? data_mem_wdata : '0;
            beat      <= '0;
            waited    <= grant_data & instr_read;
            fair      <= 1'b0;
          end
        end
        RD_BURST, WR_BURST: begin
          if (pmem_resp) begin
            beat <= last_beat ? '0 : beat + 1'b1;
          end
          waited <= waited & instr_read;
        end
        RESP: begin
          fair <= txn_data & waited & instr_read;
          if (txn_data) begin
            data_rdata_q <= resp_word;
          end else begin
            instr_rdata_q <= resp_word;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registers only
  always_comb begin
    pmem_read       = (state == RD_BURST);
    pmem_write      = (state == WR_BURST);
    pmem_address    = (state == RD_BURST || state == WR_BURST)
                      ? {txn_addr[31:OFS], {OFS{1'b0}}} : '0;
    pmem_wdata      = (state == WR_BURST) ? line[beat] : '0;
    instr_mem_resp  = (state == RESP) && !txn_data;
    data_mem_resp   = (state == RESP) && txn_data;
    instr_mem_rdata = instr_mem_resp ? resp_word : instr_rdata_q;
    data_mem_rdata  = data_mem_resp ? resp_word : data_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized concurrent traffic on
// both core ports against a behavioural line memory model.
module tb_mem_arbiter;

  localparam int BEATS = 4;

  logic        clk;
  logic        rst;
  logic        instr_read;
  logic [31:0] instr_mem_address;
  logic        instr_mem_resp;
  logic [31:0] instr_mem_rdata;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_mem_address;
  logic [31:0] data_mem_wdata;
  logic        data_mem_resp;
  logic [31:0] data_mem_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic        pmem_resp;
  logic [63:0] pmem_rdata;

  mem_arbiter #(.BEATS(BEATS)) dut (
    .clk              (clk),
    .rst              (rst),
    .instr_read       (instr_read),
    .instr_mem_address(instr_mem_address),
    .instr_mem_resp   (instr_mem_resp),
    .instr_mem_rdata  (instr_mem_rdata),
    .data_read        (data_read),
    .data_write       (data_write),
    .data_mbe         (data_mbe),
    .data_mem_address (data_mem_address),
    .data_mem_wdata   (data_mem_wdata),
    .data_mem_resp    (data_mem_resp),
    .data_mem_rdata   (data_mem_rdata),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_resp        (pmem_resp),
    .pmem_rdata       (pmem_rdata)
  );

  // Physical memory behind pmem (smem) and the reference model (mmem),
  // both as 32 beats of 64 bits covering addresses 0x00..0xFF.
  logic [63:0] smem [32];
  logic [63:0] mmem [32];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int resp_pct = 100;
  int rd_beats = 0;
  int wr_beats = 0;
  int last_wr_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // pmem responder: one beat per accepted cycle, random wait states
  initial begin
    int sbeat;
    int li;
    logic [31:0] burst_addr;
    sbeat = 0;
    burst_addr = '0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      pmem_resp = 1'b0;
      if (!rst || !(pmem_read || pmem_write)) begin
        sbeat = 0;
      end else if ($urandom_range(0, 99) < resp_pct) begin
        if (sbeat == 0) burst_addr = pmem_address;
        else check("pmem_addr_stable", pmem_address, burst_addr);
        li = (int'(pmem_address[7:3]) + sbeat) & 31;
        if (pmem_read) begin
          pmem_rdata = smem[li];
          rd_beats++;
        end else begin
          smem[li] = pmem_wdata;
          wr_beats++;
          last_wr_cyc = cyc;
        end
        pmem_resp = 1'b1;
        sbeat = (sbeat + 1) % BEATS;
      end
    end
  end

  task automatic wait_any(input int bound, output int who, output int at);
    int n;
    who = 0;
    at = 0;
    n = 0;
    while (who == 0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
      if (data_mem_resp) begin
        who = 1;
        at = cyc;
      end else if (instr_mem_resp) begin
        who = 2;
        at = cyc;
      end
    end
  endtask

  task automatic data_issue(input logic rd, input logic wr, input logic [3:0] mbe,
                            input logic [31:0] addr, input logic [31:0] wd);
    data_read = rd;
    data_write = wr;
    data_mbe = mbe;
    data_mem_address = addr;
    data_mem_wdata = wd;
  endtask

  task automatic instr_driver(input int count);
    int a;
    int gap;
    int n;
    logic [31:0] exp;
    logic done;
    for (int k = 0; k < count; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      a = $urandom_range(0, 63);
      instr_mem_address = 32'(a * 4);
      instr_read = 1'b1;
      done = 1'b0;
      n = 0;
      while (!done && n < 400) begin
        @(posedge clk);
        #1;
        n++;
        if (instr_mem_resp) begin
          exp = (a % 2 == 1) ? mmem[a / 2][63:32] : mmem[a / 2][31:0];
          check("rnd_instr_rdata", instr_mem_rdata, exp);
          done = 1'b1;
        end
      end
      instr_read = 1'b0;
      if (!done) begin
        check("rnd_instr_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic data_driver(input int count);
    int a;
    int gap;
    int kind;
    int n;
    int half;
    logic [3:0] mbe;
    logic [31:0] wd;
    logic [31:0] exp;
    logic is_wr;
    logic done;
    for (int k = 0; k < count; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      a = $urandom_range(0, 63);
      kind = $urandom_range(0, 3);
      mbe = 4'($urandom_range(0, 15));
      wd = $urandom;
      is_wr = (kind != 0);
      data_issue(kind == 0 || kind == 2, kind != 0, mbe,
                 32'(a * 4 + $urandom_range(0, 3)), wd);
      done = 1'b0;
      n = 0;
      while (!done && n < 400) begin
        @(posedge clk);
        #1;
        n++;
        if (data_mem_resp) begin
          half = a % 2;
          if (is_wr) begin
            for (int i = 0; i < 4; i++) begin
              if (mbe[i]) mmem[a / 2][half*32 + i*8 +: 8] = wd[i*8 +: 8];
            end
          end
          exp = (half == 1) ? mmem[a / 2][63:32] : mmem[a / 2][31:0];
          check(is_wr ? "rnd_store_rdata" : "rnd_load_rdata", data_mem_rdata, exp);
          done = 1'b1;
        end
      end
      data_issue(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      if (!done) begin
        check("rnd_data_timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    int who;
    int at;
    int c0;
    int rd0;
    int wr0;
    int spurious;
    int n;
    logic addr_seen;

    rst = 1'b0;
    instr_read = 1'b0;
    instr_mem_address = '0;
    data_issue(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) smem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_addr", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    check("rst_resps", {instr_mem_resp, data_mem_resp}, 0);
    check("rst_rdata", {instr_mem_rdata, data_mem_rdata}, 0);
    rst = 1'b1;

    // Instruction fetch, zero-wait pmem
    smem[12] = 64'hAAAA_BBBB_CCCC_DDDD;
    smem[13] = 64'h1111_1111_2222_2222;
    smem[14] = 64'h3333_3333_4444_4444;
    smem[15] = 64'h5555_5555_6666_6666;
    @(posedge clk); #1;
    instr_mem_address = 32'h0000_0064;
    instr_read = 1'b1;
    c0 = cyc;
    addr_seen = 1'b0;
    spurious = 0;
    who = 0;
    at = 0;
    for (int i = 0; i < 30 && who == 0; i++) begin
      @(posedge clk); #1;
      if (pmem_read && !addr_seen) begin
        check("fetch_pmem_addr", pmem_address, 32'h60);
        addr_seen = 1'b1;
      end
      if (data_mem_resp) spurious++;
      if (instr_mem_resp) begin
        who = 2;
        at = cyc;
      end
    end
    check("fetch_port", who, 2);
    check("fetch_latency", at, c0 + 5);
    check("fetch_rdata", instr_mem_rdata, 32'hAAAA_BBBB);
    check("fetch_no_data_resp", spurious, 0);
    instr_read = 1'b0;
    @(posedge clk); #1;
    check("fetch_resp_pulse", instr_mem_resp, 0);
    check("fetch_rdata_hold", instr_mem_rdata, 32'hAAAA_BBBB);

    // Full-word store into a zero line
    for (int i = 0; i < 4; i++) smem[i] = '0;
    wr0 = wr_beats;
    data_issue(1'b0, 1'b1, 4'hF, 32'h0000_0008, 32'hDEAD_BEEF);
    wait_any(60, who, at);
    data_issue(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("sw_port", who, 1);
    check("sw_wr_beats", wr_beats - wr0, 4);
    check("sw_resp_timing", at, last_wr_cyc + 1);
    check("sw_beat0", smem[0], 64'h0);
    check("sw_beat1", smem[1], 64'h0000_0000_DEAD_BEEF);
    check("sw_beat2", smem[2], 64'h0);
    check("sw_beat3", smem[3], 64'h0);

    // Byte store into upper word of beat 0
    smem[0] = 64'h1122_3344_5566_7788;
    @(posedge clk); #1;
    data_issue(1'b0, 1'b1, 4'b0100, 32'h0000_0004, 32'h00AB_0000);
    wait_any(60, who, at);
    data_issue(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("sb_port", who, 1);
    check("sb_beat0", smem[0], 64'h11AB_3344_5566_7788);
    check("sb_rdata", data_mem_rdata, 32'h11AB_3344);
    check("sb_beat1_kept", smem[1], 64'h0000_0000_DEAD_BEEF);

    // Store with no byte enables: read burst only
    @(posedge clk); #1;
    rd0 = rd_beats;
    wr0 = wr_beats;
    data_issue(1'b0, 1'b1, 4'b0000, 32'h0000_0040, 32'hFFFF_FFFF);
    wait_any(60, who, at);
    data_issue(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("mbe0_port", who, 1);
    check("mbe0_rd_beats", rd_beats - rd0, 4);
    check("mbe0_wr_beats", wr_beats - wr0, 0);

    // Arbitration: data first, then instr once by fairness, then data
    @(posedge clk); #1;
    instr_mem_address = 32'h0000_0020;
    instr_read = 1'b1;
    data_issue(1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0);
    wait_any(60, who, at);
    check("arb_first_data", who, 1);
    data_mem_address = 32'h0000_0048;
    wait_any(60, who, at);
    check("arb_second_instr", who, 2);
    instr_read = 1'b0;
    wait_any(60, who, at);
    check("arb_third_data", who, 1);
    data_issue(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset during beat 2 of a write burst
    smem[24] = 64'h0BAD_F00D_1234_5678;
    smem[25] = 64'h0;
    @(posedge clk); #1;
    wr0 = wr_beats;
    data_issue(1'b0, 1'b1, 4'hF, 32'h0000_0080, 32'h1234_5678);
    n = 0;
    while (wr_beats - wr0 < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #2;
    check("rst_mid_pre_write", pmem_write, 1);
    rst = 1'b0;
    data_issue(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    instr_mem_address = 32'h0000_00C4;
    instr_read = 1'b1;
    #1;
    check("rst_mid_pmem_write", pmem_write, 0);
    check("rst_mid_pmem_read", pmem_read, 0);
    check("rst_mid_pmem_addr", pmem_address, 0);
    check("rst_mid_pmem_wdata", pmem_wdata, 0);
    check("rst_mid_data_resp", data_mem_resp, 0);
    repeat (2) @(posedge clk);
    #2;
    rd0 = rd_beats;
    rst = 1'b1;
    wait_any(60, who, at);
    instr_read = 1'b0;
    check("rst_after_port", who, 2);
    check("rst_after_rdata", instr_mem_rdata, 32'h0BAD_F00D);
    check("rst_after_rd_beats", rd_beats - rd0, 4);

    // Randomized concurrent traffic against the line model
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      smem[i] = {$urandom, $urandom};
      mmem[i] = smem[i];
    end
    resp_pct = 70;
    fork
      instr_driver(40);
      data_driver(40);
    join
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("rnd_mem_%0d", i), smem[i], mmem[i]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL global_timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
